// File: rtl/cnn_relu_maxpool_if.sv
// Stream bundle for cnn_relu_maxpool: raster feature-map beats in, pooled pixels out.
// master = upstream producer / consumer side, slave = the pooling block.
interface cnn_relu_maxpool_if #(
   parameter int O_F_BW = 23,
   parameter int CO     = 3,
   parameter int IW     = 24,
   parameter int IH     = 24
);
   localparam int PXW = (IW / 2 > 1) ? $clog2(IW / 2) : 1;
   localparam int PYW = (IH / 2 > 1) ? $clog2(IH / 2) : 1;

   logic                 i_valid;
   logic [CO*O_F_BW-1:0] i_fmap;
   logic                 o_valid;
   logic [CO*O_F_BW-1:0] o_pool;
   logic [PXW-1:0]       o_px;
   logic [PYW-1:0]       o_py;
   logic                 o_done;

   modport master (output i_valid, i_fmap,
                   input  o_valid, o_pool, o_px, o_py, o_done);
   modport slave  (input  i_valid, i_fmap,
                   output o_valid, o_pool, o_px, o_py, o_done);
endinterface

// File: rtl/cnn_relu_maxpool.sv
// Streaming per-channel 2x2/stride-2 max pool with optional ReLU on a raster feature map.
// Define POOL_RELU_EN to clamp negative pooled values to zero.

module cnn_relu_maxpool_lane #(
   parameter int W = 23
) (
   input  logic signed [W-1:0] pair,
   input  logic signed [W-1:0] din,
   input  logic signed [W-1:0] rbuf,
   output logic signed [W-1:0] hmax,
   output logic signed [W-1:0] pooled
);
   logic signed [W-1:0] vmax;

   always_comb begin
      hmax = (din > pair) ? din : pair;
      vmax = (rbuf > hmax) ? rbuf : hmax;
`ifdef POOL_RELU_EN
      pooled = vmax[W-1] ? '0 : vmax;
`else
      pooled = vmax;
`endif
   end
endmodule

module cnn_relu_maxpool #(
   parameter int O_F_BW = 23,
   parameter int CO     = 3,
   parameter int IW     = 24,
   parameter int IH     = 24
) (
   input logic             clk,
   input logic             reset_n,
   cnn_relu_maxpool_if.slave s
);
   localparam int XW  = $clog2(IW);
   localparam int YW  = $clog2(IH);
   localparam int PXW = (IW / 2 > 1) ? $clog2(IW / 2) : 1;
   localparam int PYW = (IH / 2 > 1) ? $clog2(IH / 2) : 1;

   typedef logic [CO-1:0][O_F_BW-1:0] pix_t;

   if ((IW % 2) != 0 || (IH % 2) != 0 || IW < 2 || IH < 2) begin : g_bad_geom
      $error("cnn_relu_maxpool: IW and IH must be even and >= 2");
   end

   logic [XW-1:0]  x_q, x_d;
   logic [YW-1:0]  y_q, y_d;
   pix_t           pair_q, pair_d;
   pix_t           rowbuf_q [IW/2];
   pix_t           rowbuf_d [IW/2];
   logic           valid_q, valid_d;
   logic           done_q, done_d;
   pix_t           pool_q, pool_d;
   logic [PXW-1:0] px_q, px_d;
   logic [PYW-1:0] py_q, py_d;

   pix_t           din, hmax, pooled;
   logic [PXW-1:0] col;
   logic [PYW-1:0] row;
   logic           x_last, y_last;

   assign din    = s.i_fmap;
   assign col    = PXW'(x_q >> 1);
   assign row    = PYW'(y_q >> 1);
   assign x_last = (x_q == XW'(IW - 1));
   assign y_last = (y_q == YW'(IH - 1));

   for (genvar c = 0; c < CO; c++) begin : g_lane
      cnn_relu_maxpool_lane #(.W(O_F_BW)) u_lane (
         .pair   (pair_q[c]),
         .din    (din[c]),
         .rbuf   (rowbuf_q[col][c]),
         .hmax   (hmax[c]),
         .pooled (pooled[c])
      );
   end

   always_comb begin
      x_d      = x_q;
      y_d      = y_q;
      pair_d   = pair_q;
      rowbuf_d = rowbuf_q;
      valid_d  = 1'b0;
      done_d   = 1'b0;
      pool_d   = pool_q;
      px_d     = px_q;
      py_d     = py_q;
      if (s.i_valid) begin
         x_d = x_last ? '0 : x_q + 1'b1;
         if (x_last) y_d = y_last ? '0 : y_q + 1'b1;
         // even rows park their horizontal max; odd rows close the 2x2 window
         if (!x_q[0]) begin
            pair_d = din;
         end else if (!y_q[0]) begin
            rowbuf_d[col] = hmax;
         end else begin
            valid_d = 1'b1;
            done_d  = x_last & y_last;
            pool_d  = pooled;
            px_d    = col;
            py_d    = row;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         x_q     <= '0;
         y_q     <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         pool_q  <= '0;
         px_q    <= '0;
         py_q    <= '0;
      end else begin
         x_q     <= x_d;
         y_q     <= y_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         pool_q  <= pool_d;
         px_q    <= px_d;
         py_q    <= py_d;
      end
   end

   // data-path storage needs no reset; counters decide what is live
   always_ff @(posedge clk) begin
      pair_q   <= pair_d;
      rowbuf_q <= rowbuf_d;
   end

   assign s.o_valid = valid_q;
   assign s.o_done  = done_q;
   assign s.o_pool  = pool_q;
   assign s.o_px    = px_q;
   assign s.o_py    = py_q;
endmodule

// File: tb/tb_cnn_relu_maxpool.sv
// Randomized and directed bench for cnn_relu_maxpool against a frame-level 2x2 max/ReLU model.
module tb_cnn_relu_maxpool;
   localparam int W    = 23;
   localparam int CO   = 3;
   localparam int IW   = 24;
   localparam int IH   = 24;
   localparam int NPIX = IW * IH;
   localparam int NOUT = (IW / 2) * (IH / 2);

   typedef logic [CO-1:0][W-1:0] pix_t;
   typedef struct {
      int   due;
      pix_t val;
      int   px;
      int   py;
      bit   done;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   cyc = 0;
   bit   rst_smp = 1'b0;

   cnn_relu_maxpool_if #(.O_F_BW(W), .CO(CO), .IW(IW), .IH(IH)) bus ();

   cnn_relu_maxpool #(.O_F_BW(W), .CO(CO), .IW(IW), .IH(IH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .s       (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) begin
      cyc     <= cyc + 1;
      rst_smp <= reset_n;
   end

   pix_t frame [NPIX];
   exp_t q [$];
   int   n_cmp = 0, n_bad = 0;
   int   n_valid = 0, n_done = 0, done_at = 0;
   pix_t pin00, pin_last, first_val;
   int   first_px, first_py;
   pix_t last_pool = '0;
   int   last_px = 0, last_py = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference: signed max over the 2x2 window of the stored frame, then optional clamp.
   function automatic pix_t model_pool(input int px, input int py);
      pix_t r;
      for (int c = 0; c < CO; c++) begin
         logic signed [W-1:0] m, v;
         m = frame[2*py*IW + 2*px][c];
         for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++) begin
               v = frame[(2*py+dy)*IW + 2*px + dx][c];
               if (v > m) m = v;
            end
`ifdef POOL_RELU_EN
         if (m < 0) m = '0;
`endif
         r[c] = m;
      end
      return r;
   endfunction

   task automatic fill_ramp();
      for (int p = 0; p < NPIX; p++)
         for (int c = 0; c < CO; c++)
            frame[p][c] = W'(25 * (28 * (p / IW) + (p % IW)) + 1475);
   endtask

   task automatic fill_rand();
      for (int p = 0; p < NPIX; p++)
         for (int c = 0; c < CO; c++)
            frame[p][c] = W'($urandom);
   endtask

   task automatic fill_const(input logic [W-1:0] v);
      for (int p = 0; p < NPIX; p++)
         for (int c = 0; c < CO; c++)
            frame[p][c] = v;
   endtask

   task automatic clear_stats();
      n_valid = 0; n_done = 0; done_at = 0;
      pin00 = 'x; pin_last = 'x; first_val = 'x;
      first_px = -1; first_py = -1;
   endtask

   task automatic send_frame(input int gap_mode, input int nbeats);
      exp_t e;
      int   g, x, y;
      for (int p = 0; p < nbeats; p++) begin
         if (gap_mode > 0 && p > 0) begin
            g = 1 + (($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : 0);
            repeat (g) begin
               @(posedge clk); #1;
               bus.i_valid = 1'b0;
               bus.i_fmap  = {CO*W{1'b1}} & {$urandom, $urandom, $urandom};
            end
         end
         @(posedge clk); #1;
         bus.i_valid = 1'b1;
         bus.i_fmap  = frame[p];
         x = p % IW;
         y = p / IW;
         if ((x % 2) == 1 && (y % 2) == 1) begin
            e.due  = cyc + 1;
            e.val  = model_pool(x / 2, y / 2);
            e.px   = x / 2;
            e.py   = y / 2;
            e.done = (x == IW - 1) && (y == IH - 1);
            q.push_back(e);
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         bus.i_valid = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset_n = 1'b0;
      bus.i_valid = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      q.delete();
   endtask

   // Cycle-accurate compare of every output against the model queue.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_smp) begin
            chk("rst_valid", bus.o_valid, 0);
            chk("rst_done", bus.o_done, 0);
            chk("rst_pool", bus.o_pool, 0);
            chk("rst_px", bus.o_px, 0);
            chk("rst_py", bus.o_py, 0);
            last_pool = '0; last_px = 0; last_py = 0;
         end else if (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            if (e.due < cyc) chk("late_expect", 128'(cyc), 128'(e.due));
            chk("valid", bus.o_valid, 1);
            chk("pool", bus.o_pool, e.val);
            chk("px", bus.o_px, 128'(e.px));
            chk("py", bus.o_py, 128'(e.py));
            chk("done", bus.o_done, 128'(e.done));
            last_pool = e.val; last_px = e.px; last_py = e.py;
         end else begin
            chk("idle_valid", bus.o_valid, 0);
            chk("idle_done", bus.o_done, 0);
            chk("hold_pool", bus.o_pool, last_pool);
            chk("hold_px", bus.o_px, 128'(last_px));
            chk("hold_py", bus.o_py, 128'(last_py));
         end
         if (rst_smp && bus.o_valid === 1'b1) begin
            n_valid++;
            if (n_valid == 1) begin
               first_val = bus.o_pool; first_px = int'(bus.o_px); first_py = int'(bus.o_py);
            end
            if (bus.o_px == 0 && bus.o_py == 0) pin00 = bus.o_pool;
            if (bus.o_px == IW/2-1 && bus.o_py == IH/2-1) pin_last = bus.o_pool;
         end
         if (rst_smp && bus.o_done === 1'b1) begin
            n_done++;
            done_at = n_valid;
         end
      end
   end

   initial begin
      pix_t ramp00, ramplast, mix_exp, neg_exp;
      for (int c = 0; c < CO; c++) begin
         ramp00[c]   = W'(2200);
         ramplast[c] = W'(18150);
      end
`ifdef POOL_RELU_EN
      mix_exp = {W'(0), W'(0), W'(7)};
      neg_exp = '0;
`else
      mix_exp = {W'(0), W'(23'h7FFFFF), W'(7)};
      neg_exp = {CO{W'(23'h400000)}};
`endif
      bus.i_valid = 1'b0;
      bus.i_fmap  = '0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;

      // continuous ramp frame
      fill_ramp(); clear_stats();
      send_frame(0, NPIX); idle(3);
      chk("ramp_pulses", n_valid, NOUT);
      chk("ramp_dones", n_done, 1);
      chk("ramp_done_at", done_at, NOUT);
      chk("ramp_00", pin00, ramp00);
      chk("ramp_last", pin_last, ramplast);

      // mixed-sign first window
      fill_rand();
      frame[0][0] = W'(-3);  frame[1][0] = W'(7);  frame[IW][0] = W'(-10); frame[IW+1][0] = W'(2);
      frame[0][1] = W'(-1);  frame[1][1] = W'(-2); frame[IW][1] = W'(-3);  frame[IW+1][1] = W'(-4);
      frame[0][2] = '0;      frame[1][2] = '0;     frame[IW][2] = '0;      frame[IW+1][2] = '0;
      clear_stats();
      send_frame(0, NPIX); idle(3);
      chk("mixed_00", pin00, mix_exp);

      // gapped ramp
      fill_ramp(); clear_stats();
      send_frame(1, NPIX); idle(3);
      chk("gap_pulses", n_valid, NOUT);
      chk("gap_00", pin00, ramp00);
      chk("gap_last", pin_last, ramplast);

      // reset mid-frame, then a clean frame
      send_frame(0, 100);
      do_reset(); clear_stats();
      send_frame(0, NPIX); idle(3);
      chk("rstmid_pulses", n_valid, NOUT);
      chk("rstmid_first_px", first_px, 0);
      chk("rstmid_first_py", first_py, 0);
      chk("rstmid_first_val", first_val, ramp00);

      // back-to-back frames
      clear_stats();
      send_frame(0, NPIX); send_frame(0, NPIX); idle(3);
      chk("b2b_pulses", n_valid, 2 * NOUT);
      chk("b2b_dones", n_done, 2);
      chk("b2b_00", pin00, ramp00);

      // most negative value everywhere
      fill_const(W'(23'h400000)); clear_stats();
      send_frame(0, NPIX); idle(3);
      chk("neg_00", pin00, neg_exp);
      chk("neg_last", pin_last, neg_exp);

      // random frames, random gaps
      for (int f = 0; f < 2; f++) begin
         fill_rand(); clear_stats();
         send_frame(f, NPIX); idle(3);
         chk("rand_pulses", n_valid, NOUT);
      end

      idle(2);
      chk("queue_drained", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
